// File: rtl/fountain_lt_encoder.sv
// rtl/fountain_lt_encoder.sv - LT fountain encoder: buffers K source bytes, emits systematic then LFSR-coded symbols
module fountain_lt_encoder #(
  parameter int          K    = 8,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         ena_i,
  input  logic         clear_i,
  input  logic         load_valid_i,
  input  logic [7:0]   load_data_i,
  output logic         load_ready_o,
  output logic         sym_valid_o,
  input  logic         sym_ready_i,
  output logic [7:0]   sym_data_o,
  output logic [K-1:0] sym_mask_o,
  output logic [7:0]   sym_index_o
);

  localparam int          CW   = $clog2(K);
  localparam logic [15:0] TAPS = 16'hB400;

  // LOAD -> SETUP (one cycle) -> GEN (K cycles) -> OUT -> GEN ...
  // SETUP gives the first symbol the same K+1 latency as a handshake-to-next-symbol period.
  typedef enum logic [1:0] {S_LOAD, S_SETUP, S_GEN, S_OUT} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] gen_q;
  logic [7:0]    buf_q [K];
  logic [7:0]    acc_q;
  logic [K-1:0]  mask_q;
  logic [15:0]   lfsr_q;
  logic [7:0]    idx_q;
  logic          load_ready_q;
  logic          sym_valid_q;
  logic [7:0]    sym_data_q;
  logic [K-1:0]  sym_mask_q;

  logic [7:0]    entry_idx;
  logic [7:0]    entry_mod;
  logic [15:0]   lfsr_adv;
  logic          entry_coded;
  logic [K-1:0]  rr_mask;
  logic [K-1:0]  entry_mask;
  logic [7:0]    acc_d;

  // Mask for the symbol about to be generated, plus the next accumulator value
  always_comb begin
    // Leaving OUT means the current symbol is consumed, so the new symbol uses index + 1
    entry_idx   = (state_q == S_OUT) ? idx_q + 8'd1 : idx_q;
    entry_mod   = entry_idx % 8'(K);
    lfsr_adv    = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 16'h0000);
    entry_coded = (entry_idx >= 8'(K));
    rr_mask     = {{(K-1){1'b0}}, 1'b1} << entry_mod;
    if (!entry_coded) begin
      entry_mask = rr_mask;
    end else if (lfsr_adv[K-1:0] == '0) begin
      // A zero mask would carry no information; fall back to a single source byte
      entry_mask = rr_mask;
    end else begin
      entry_mask = lfsr_adv[K-1:0];
    end
    acc_d = acc_q ^ (mask_q[gen_q] ? buf_q[gen_q] : 8'h00);
  end

  // Main FSM with registered outputs; clear overrides everything, ena freezes everything
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_LOAD;
      cnt_q        <= '0;
      gen_q        <= '0;
      for (int i = 0; i < K; i++) buf_q[i] <= 8'h00;
      acc_q        <= 8'h00;
      mask_q       <= '0;
      lfsr_q       <= SEED;
      idx_q        <= 8'h00;
      load_ready_q <= 1'b1;
      sym_valid_q  <= 1'b0;
      sym_data_q   <= 8'h00;
      sym_mask_q   <= '0;
    end else if (ena_i) begin
      if (clear_i) begin
        state_q      <= S_LOAD;
        cnt_q        <= '0;
        gen_q        <= '0;
        acc_q        <= 8'h00;
        idx_q        <= 8'h00;
        lfsr_q       <= SEED;
        load_ready_q <= 1'b1;
        sym_valid_q  <= 1'b0;
      end else begin
        case (state_q)
          S_LOAD: begin
            if (load_valid_i) begin
              buf_q[cnt_q] <= load_data_i;
              if (cnt_q == CW'(K-1)) begin
                cnt_q        <= '0;
                load_ready_q <= 1'b0;
                state_q      <= S_SETUP;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
          S_SETUP, S_OUT: begin
            if (state_q == S_SETUP || sym_ready_i) begin
              if (state_q == S_OUT) begin
                idx_q       <= idx_q + 8'd1;
                sym_valid_q <= 1'b0;
              end
              // LFSR only steps for coded symbols, so backpressure never advances it
              if (entry_coded) lfsr_q <= lfsr_adv;
              mask_q  <= entry_mask;
              acc_q   <= 8'h00;
              gen_q   <= '0;
              state_q <= S_GEN;
            end
          end
          S_GEN: begin
            if (gen_q == CW'(K-1)) begin
              sym_data_q  <= acc_d;
              sym_mask_q  <= mask_q;
              sym_valid_q <= 1'b1;
              state_q     <= S_OUT;
            end else begin
              acc_q <= acc_d;
              gen_q <= gen_q + CW'(1);
            end
          end
          default: state_q <= S_LOAD;
        endcase
      end
    end
  end

  assign load_ready_o = load_ready_q;
  assign sym_valid_o  = sym_valid_q;
  assign sym_data_o   = sym_data_q;
  assign sym_mask_o   = sym_mask_q;
  assign sym_index_o  = idx_q;

endmodule

// File: tb/tb_fountain_lt_encoder.sv
// tb/tb_fountain_lt_encoder.sv - scoreboard bench for fountain_lt_encoder
module tb_fountain_lt_encoder;

  localparam int K = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b1;
  logic         clear = 1'b0;
  logic         load_valid = 1'b0;
  logic [7:0]   load_data = 8'h00;
  logic         load_ready;
  logic         sym_valid;
  logic         sym_ready = 1'b0;
  logic [7:0]   sym_data;
  logic [K-1:0] sym_mask;
  logic [7:0]   sym_index;

  int checks = 0;
  int errors = 0;

  logic [7:0]   src [K];
  logic [15:0]  m_lfsr;
  logic [7:0]   m_idx;
  logic [7:0]   q_data [$];
  logic [K-1:0] q_mask [$];
  logic [7:0]   q_idx  [$];

  always #5 clk = ~clk;

  fountain_lt_encoder #(.K(K), .SEED(16'hACE1)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ena_i        (ena),
    .clear_i      (clear),
    .load_valid_i (load_valid),
    .load_data_i  (load_data),
    .load_ready_o (load_ready),
    .sym_valid_o  (sym_valid),
    .sym_ready_i  (sym_ready),
    .sym_data_o   (sym_data),
    .sym_mask_o   (sym_mask),
    .sym_index_o  (sym_index)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; ena = 1'b1; clear = 1'b0; load_valid = 1'b0; sym_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic model_reset;
    m_lfsr = 16'hACE1;
    m_idx  = 8'h00;
    q_data.delete();
    q_mask.delete();
    q_idx.delete();
  endtask

  // Reference model: push the next n expected symbols
  task automatic model_push(input int n);
    for (int s = 0; s < n; s++) begin
      logic [K-1:0] m;
      logic [7:0]   d;
      m = '0;
      if (m_idx < 8'(K)) begin
        m[m_idx % K] = 1'b1;
      end else begin
        m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        m = m_lfsr[K-1:0];
        if (m == '0) m[m_idx % K] = 1'b1;
      end
      d = 8'h00;
      for (int j = 0; j < K; j++) if (m[j]) d = d ^ src[j];
      q_data.push_back(d);
      q_mask.push_back(m);
      q_idx.push_back(m_idx);
      m_idx = m_idx + 8'd1;
    end
  endtask

  task automatic load_src;
    for (int i = 0; i < K; i++) begin
      load_valid = 1'b1;
      load_data  = src[i];
      tick();
    end
    load_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (sym_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
      lat++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL sym_valid_timeout got 0 exp 1 after %0d cycles", lat);
    end
  endtask

  // Consume n symbols with sym_ready held high and compare against the scoreboard
  task automatic collect(input int n);
    int lat;
    bit ok;
    sym_ready = 1'b1;
    for (int s = 0; s < n; s++) begin
      logic [7:0]   ed;
      logic [K-1:0] em;
      logic [7:0]   ei;
      wait_valid(lat, ok);
      if (!ok) return;
      ed = q_data.pop_front();
      em = q_mask.pop_front();
      ei = q_idx.pop_front();
      checks++;
      if (sym_data !== ed) begin errors++; $display("FAIL sym_data idx %0d got %h exp %h", ei, sym_data, ed); end
      checks++;
      if (sym_mask !== em) begin errors++; $display("FAIL sym_mask idx %0d got %h exp %h", ei, sym_mask, em); end
      checks++;
      if (sym_index !== ei) begin errors++; $display("FAIL sym_index got %0d exp %0d", sym_index, ei); end
      checks++;
      if (sym_mask === '0) begin errors++; $display("FAIL zero_mask idx %0d got %h exp nonzero", ei, sym_mask); end
      if (s > 0) begin
        checks++;
        if (lat != K) begin errors++; $display("FAIL b2b_period got %0d exp %0d", lat + 1, K + 1); end
      end
      tick();
    end
  endtask

  task automatic set_src_seq(input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < K; i++) src[i] = base + step * 8'(i);
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rst_load_ready got %b exp 1", load_ready); end
    checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL rst_sym_valid got %b exp 0", sym_valid); end
    checks++; if (sym_data !== 8'h00) begin errors++; $display("FAIL rst_sym_data got %h exp 00", sym_data); end
    checks++; if (sym_mask !== '0) begin errors++; $display("FAIL rst_sym_mask got %h exp 00", sym_mask); end
    checks++; if (sym_index !== 8'h00) begin errors++; $display("FAIL rst_sym_index got %h exp 00", sym_index); end
  endtask

  task automatic test_systematic;
    int lat;
    bit ok;
    do_reset();
    set_src_seq(8'h11, 8'h11);
    model_reset();
    model_push(K);
    sym_ready = 1'b1;
    load_src();
    wait_valid(lat, ok);
    checks++;
    if (ok && lat != K + 1) begin errors++; $display("FAIL first_latency got %0d exp %0d", lat, K + 1); end
    collect(K);
  endtask

  task automatic test_first_coded;
    int lat;
    bit ok;
    do_reset();
    set_src_seq(8'h11, 8'h11);
    model_reset();
    model_push(K);
    load_src();
    collect(K);
    wait_valid(lat, ok);
    if (ok) begin
      checks++; if (sym_mask !== 8'h70) begin errors++; $display("FAIL coded_mask got %h exp 70", sym_mask); end
      checks++; if (sym_data !== 8'h44) begin errors++; $display("FAIL coded_data got %h exp 44", sym_data); end
      checks++; if (sym_index !== 8'd8) begin errors++; $display("FAIL coded_index got %0d exp 8", sym_index); end
      tick();
    end
  endtask

  task automatic test_backpressure;
    int lat;
    bit ok;
    do_reset();
    set_src_seq(8'h11, 8'h11);
    model_reset();
    model_push(K + 2);
    load_src();
    collect(K);
    sym_ready = 1'b0;
    wait_valid(lat, ok);
    for (int c = 0; c < 20; c++) begin
      checks++; if (sym_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc %0d got %b exp 1", c, sym_valid); end
      checks++; if (sym_data !== q_data[0]) begin errors++; $display("FAIL bp_data cyc %0d got %h exp %h", c, sym_data, q_data[0]); end
      checks++; if (sym_mask !== q_mask[0]) begin errors++; $display("FAIL bp_mask cyc %0d got %h exp %h", c, sym_mask, q_mask[0]); end
      checks++; if (sym_index !== q_idx[0]) begin errors++; $display("FAIL bp_index cyc %0d got %0d exp %0d", c, sym_index, q_idx[0]); end
      tick();
    end
    collect(2);
  endtask

  task automatic test_ena_gating;
    int lat;
    bit ok;
    do_reset();
    set_src_seq(8'h11, 8'h11);
    model_reset();
    model_push(K + 1);
    sym_ready = 1'b1;
    load_src();
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL gen_load_ready got %b exp 0", load_ready); end
    repeat (3) tick();
    ena = 1'b0;
    repeat (5) tick();
    ena = 1'b1;
    wait_valid(lat, ok);
    checks++;
    if (ok && 3 + 5 + lat != K + 1 + 5) begin errors++; $display("FAIL ena_latency got %0d exp %0d", 8 + lat, K + 6); end
    collect(K + 1);
  endtask

  task automatic test_clear;
    int lat;
    bit ok;
    do_reset();
    set_src_seq(8'h11, 8'h11);
    model_reset();
    model_push(K + 1);
    load_src();
    collect(K + 1);
    sym_ready = 1'b0;
    wait_valid(lat, ok);
    clear = 1'b1;
    sym_ready = 1'b1;
    tick();
    clear = 1'b0;
    sym_ready = 1'b0;
    checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got %b exp 0", sym_valid); end
    checks++; if (sym_index !== 8'h00) begin errors++; $display("FAIL clr_index got %0d exp 0", sym_index); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL clr_load_ready got %b exp 1", load_ready); end
    set_src_seq(8'hA0, 8'h01);
    model_reset();
    model_push(K + 4);
    load_src();
    collect(K + 4);
  endtask

  task automatic test_reset_mid;
    int lat;
    bit ok;
    do_reset();
    set_src_seq(8'h11, 8'h11);
    load_src();
    wait_valid(lat, ok);
    rst_n = 1'b0;
    #1;
    checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid got %b exp 0", sym_valid); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL async_rst_ready got %b exp 1", load_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_long_run;
    do_reset();
    for (int i = 0; i < K; i++) src[i] = 8'($urandom_range(0, 255));
    model_reset();
    model_push(300);
    load_src();
    collect(300);
  endtask

  initial begin
    test_reset();
    test_systematic();
    test_first_coded();
    test_backpressure();
    test_ena_gating();
    test_clear();
    test_reset_mid();
    test_long_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fountain_lt_encoder.md
# fountain_lt_encoder

Rateless (LT-style) fountain encoder core instantiated inside `tt_um_fountaincoder_top`, directly upstream of the top-level pin mux. It buffers K source bytes, then emits an unbounded stream of encoded symbols. The first K symbols are systematic, meaning each one is a plain copy of a source byte. Every later symbol is the XOR of a pseudo-random subset of source bytes, with the subset chosen by a 16-bit LFSR. Each symbol carries its neighbour bitmap and index so that a downstream decoder can peel the stream.

## Interface
Parameters:
- `K`, 8: number of source bytes; range 2..8; sets the `sym_mask` width.
- `SEED`, 16'hACE1: LFSR value loaded on reset and on `clear`; must be nonzero.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: clock enable. While low, all state holds and outputs hold.
- `clear` in 1: synchronous flush back to IDLE.
- `load_valid` in 1: a source byte is offered.
- `load_data` in 8: source byte.
- `load_ready` out 1: the buffer accepts a byte.
- `sym_valid` out 1: an encoded symbol is available.
- `sym_ready` in 1: the consumer accepts the symbol.
- `sym_data` out 8: encoded byte.
- `sym_mask` out K: bitmap of the source bytes XORed into `sym_data`.
- `sym_index` out 8: symbol sequence number.

## Operation
- State machine:
  - LOAD is the reset state. `load_ready` = 1.
  - Each handshake (`load_valid` & `load_ready`) writes `buf[cnt]` and increments `cnt`.
  - When the K-th byte is accepted, the FSM moves to GEN.
  - GEN runs exactly K cycles. Cycle i XORs `buf[i]` into the accumulator when `mask[i]` = 1. After cycle K-1 the FSM moves to OUT.
  - OUT holds `sym_valid` = 1. On `sym_valid` & `sym_ready` the FSM moves to GEN for the next symbol and `sym_index` increments.
- Mask selection, latched on entry to GEN:
  - When `sym_index` < K: mask = 1 << `sym_index`. The LFSR does not advance.
  - Otherwise the LFSR advances once, then mask = LFSR[K-1:0].
  - If that mask is zero, use mask = 1 << (`sym_index` mod K) instead.
- LFSR: 16-bit Galois, right shift, toggle constant 16'hB400. Next state = (s>>1) ^ (s[0] ? 16'hB400 : 0).
- `sym_index` is 8 bits and wraps 255 -> 0. After a wrap, indices 0..K-1 are systematic again. The LFSR is not reloaded on wrap.
- `clear`:
  - Has priority over every other action in the same cycle.
  - Next state is LOAD with `cnt` = 0, `sym_index` = 0, LFSR = `SEED`, `sym_valid` = 0, accumulator = 0.
  - `buf` contents are left stale; they are rewritten on the next load.
- `load_valid` is ignored outside LOAD. `load_ready` = 0 outside LOAD.
- Reset values: `load_ready` = 1, `sym_valid` = 0, `sym_data` = 0, `sym_mask` = 0, `sym_index` = 0, LFSR = `SEED`, `cnt` = 0, `buf` = 0.
- Reset mid-symbol: the partial accumulator is discarded and `sym_valid` drops asynchronously.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs; `sym_ready` does not affect `sym_valid` in the same cycle.
- First symbol: `sym_valid` rises on the (K+1)-th enabled rising edge after the edge that accepted the last source byte.
- Back-to-back symbols: with `sym_ready` held at 1, one symbol is emitted every K+1 enabled cycles.
- Backpressure: while `sym_valid` & !`sym_ready`, the signals `sym_data`, `sym_mask` and `sym_index` hold stable and the LFSR does not advance.
- `ena` = 0 for any number of cycles stretches all latencies by exactly that count.
- `clear` and a handshake in the same cycle: `clear` wins. The symbol is not counted as consumed.

## Test plan
- Systematic output: load 0x11, 0x22, …, 0x88 with `sym_ready` = 1. Required response:
  - Symbols 0..7 have `sym_data` = 0x11..0x88 and `sym_mask` = 0x01, 0x02, …, 0x80.
  - The first `sym_valid` appears 9 cycles after the last load.
- First coded symbol: same stimulus. Symbol 8 must have LFSR = 0xE270, `sym_mask` = 0x70 and `sym_data` = 0x55^0x66^0x77 = 0x44, with `sym_index` = 8.
- Backpressure: hold `sym_ready` = 0 for 20 cycles during symbol 8. Required response: outputs stay stable; after release, the symbol 9 mask equals the mask the LFSR produces from 0xE270, computed by the reference model.
- `ena` gating: drop `ena` for 5 cycles mid-GEN. Required response: the first symbol arrives exactly 5 cycles later, with unchanged data.
- `clear` during OUT, then reload 0xA0..0xA7. Required response: the first symbol is 0xA0 with `sym_index` 0, and the coded sequence repeats identically from LFSR = 0xACE1.
- Long run of 300 symbols against a scoreboard model. Required response: `sym_index` wraps 255 -> 0; indices 0..7 after the wrap are systematic; no symbol has a zero mask.
